// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded burst lock feeding one
// registered 64-bit output slot under a valid/ready handshake.
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int WIDTH     = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_src;
  logic [1:0]       r_ptr;
  logic [3:0]       r_burst_cnt;

  logic             w_can_accept;
  logic             w_grant;
  logic             w_hold;
  logic             w_xfer;
  logic [1:0]       w_sel;
  logic [1:0]       w_idx;
  logic [WIDTH-1:0] w_data;

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_grant      = |in_valid;
  // A zero count means nobody owns a burst yet, so the scan from ptr+1
  // decides; this is what gives requester 0 first priority out of reset.
  assign w_hold       = (r_burst_cnt != 4'd0) && in_valid[r_ptr] &&
                        (r_burst_cnt < LP_MAX);
  assign w_xfer       = reset_n && w_can_accept && w_grant;

  // Scan from farthest (ptr) to nearest (ptr+1) so the nearest valid wins.
  always_comb begin
    w_sel = r_ptr;
    w_idx = r_ptr;
    if (!w_hold) begin
      for (int k = 4; k >= 1; k--) begin
        w_idx = r_ptr + 2'(k);
        if (in_valid[w_idx]) w_sel = w_idx;
      end
    end
  end

  always_comb begin
    case (w_sel)
      2'd0:    w_data = in_data0;
      2'd1:    w_data = in_data1;
      2'd2:    w_data = in_data2;
      default: w_data = in_data3;
    endcase
  end

  assign in_ready = w_xfer ? (4'b0001 << w_sel) : 4'b0000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 2'd0;
      r_ptr       <= 2'd3;
      r_burst_cnt <= 4'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_src   <= w_sel;
      r_ptr       <= w_sel;
      r_burst_cnt <= ((w_sel == r_ptr) && (r_burst_cnt < LP_MAX)) ?
                     r_burst_cnt + 4'd1 : 4'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter (MAX_BURST=4 and a
// MAX_BURST=1 instance for strict round-robin).
module tb_mux4_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  in_valid, b_valid;
  logic        out_ready, b_ordy;
  logic [63:0] dtab [4];
  logic [3:0]  in_ready, b_in_ready;
  logic        out_valid, b_out_valid;
  logic [63:0] out_data, b_out_data;
  logic [1:0]  out_src, b_out_src;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mux4_rr_arbiter #(.MAX_BURST(4), .WIDTH(64)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .in_data0(dtab[0]), .in_data1(dtab[1]), .in_data2(dtab[2]), .in_data3(dtab[3]),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  mux4_rr_arbiter #(.MAX_BURST(1), .WIDTH(64)) u_rr (
    .clock(clock), .reset_n(reset_n), .in_valid(b_valid),
    .in_data0(dtab[0]), .in_data1(dtab[1]), .in_data2(dtab[2]), .in_data3(dtab[3]),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_src(b_out_src), .out_ready(b_ordy)
  );

  typedef struct {
    logic [3:0] v;
    logic       r;
    logic [3:0] er;
    logic       eov;
    logic [1:0] es;
  } vec_t;

  vec_t tbl [34];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check in_ready mid-cycle, check slot after edge.
  task automatic step(input logic [3:0] v, input logic r, input logic [3:0] er,
                      input logic eov, input logic [1:0] es);
    in_valid  = v;
    out_ready = r;
    #3;
    chk("in_ready", 64'(in_ready), 64'(er));
    @(posedge clock);
    #1;
    chk("out_valid", 64'(out_valid), 64'(eov));
    chk("out_src", 64'(out_src), 64'(es));
    chk("out_data", out_data, dtab[es]);
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] er,
                              input logic eov, input logic [1:0] es);
    vec_t t;
    t.v = v; t.r = r; t.er = er; t.eov = eov; t.es = es;
    return t;
  endfunction

  initial begin
    logic [1:0] bseq [17];
    logic [1:0] rseq [6];
    bseq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
             2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    rseq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    dtab[0] = 64'h0123_4567_89AB_CDEF;
    dtab[1] = 64'hFEDC_BA98_7654_3210;
    dtab[2] = 64'hA5A5_0000_0000_0002;
    dtab[3] = 64'h8000_0000_0000_0003;

    // Burst lock with all four requesting, back-to-back.
    for (int i = 0; i < 17; i++)
      tbl[i] = mk(4'b1111, 1'b1, 4'b0001 << bseq[i], 1'b1, bseq[i]);
    tbl[17] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0); // drain, src holds
    tbl[18] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2); // single requester
    tbl[19] = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    tbl[20] = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1); // stall x3
    tbl[21] = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1);
    tbl[22] = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1);
    tbl[23] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0); // release, accepted at once
    tbl[24] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0); // sole owner beyond expiry
    tbl[25] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
    tbl[26] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
    tbl[27] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0); // regrant, count back to 1
    tbl[28] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    tbl[29] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    tbl[30] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    tbl[31] = mk(4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1);
    tbl[32] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1);
    tbl[33] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);

    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    b_valid   = 4'b0000;
    b_ordy    = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 34; i++)
      step(tbl[i].v, tbl[i].r, tbl[i].er, tbl[i].eov, tbl[i].es);

    // Early drop: owner 0 for two beats, then it leaves and 1 takes over.
    step(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
    step(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
    step(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
    step(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);

    // Asynchronous reset pulse between clock edges.
    in_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_out_src", 64'(out_src), 64'd0);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);

    // Strict round-robin instance.
    in_valid = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      b_valid = 4'b1111;
      b_ordy  = 1'b1;
      #3;
      chk("rr_in_ready", 64'(b_in_ready), 64'(4'b0001 << rseq[i]));
      @(posedge clock);
      #1;
      chk("rr_out_valid", 64'(b_out_valid), 64'd1);
      chk("rr_out_src", 64'(b_out_src), 64'(rseq[i]));
      chk("rr_out_data", b_out_data, dtab[rseq[i]]);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
